// File: rtl/can_tx_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// can_tx_scheduler_pkg
// Shared constants and types for the CAN transmit scheduler.
//   TOTAL_NODES   number of CAN nodes (even; nodes are paired i <-> i^1)
//   DATA_SIZE     packet payload width in bits
//   ID_SIZE       CAN identifier width
//   MAX_RETRY     retransmit attempts per frame before the frame is dropped
//   sched_state_t scheduler FSM states
//   can_id_t      one CAN identifier
// -----------------------------------------------------------------------------
package can_tx_scheduler_pkg;

  localparam int TOTAL_NODES = 4;
  localparam int DATA_SIZE   = 64;
  localparam int ID_SIZE     = 11;
  localparam int MAX_RETRY   = 8;

  typedef enum logic [1:0] {
    CFG_WAIT = 2'd0,
    IDLE     = 2'd1,
    FETCH    = 2'd2
  } sched_state_t;

  typedef logic [ID_SIZE-1:0] can_id_t;

endpackage

// File: rtl/can_tx_scheduler_rr_arbiter.sv
// -----------------------------------------------------------------------------
// can_tx_scheduler_rr_arbiter
// Purely combinational round-robin pick: grants the first requesting bit at or
// after ptr, wrapping around.
//   req  in  N   request vector
//   ptr  in  PW  index where the search starts
//   gnt  out N   one-hot grant (all zero when req is empty)
// -----------------------------------------------------------------------------
module can_tx_scheduler_rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  logic [PW-1:0] idx;

  // Walk from farthest to nearest so the nearest requester is written last.
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = PW'((int'(ptr) + k) % N);
      if (req[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/can_tx_scheduler.sv
// -----------------------------------------------------------------------------
// can_tx_scheduler
// Hands packets from a valid/ready stream to CAN nodes in round-robin order,
// drives each node's payload and TX/RX identifiers, and handles retransmit,
// abort and completion per node.
//   clock, reset   system clock, synchronous active-high reset
//   cfg_valid      strobe that loads the ID table from cfg_id
//   cfg_id         node i ID at [i*ID_SIZE +: ID_SIZE]
//   cfg_done       sticky: ID table has been loaded since reset
//   pkt_valid/pkt_data/pkt_ready  packet source handshake
//   data_in_req    node i wants a new frame
//   retransmit     node i must resend (ID forced to 0 while retrying)
//   tx_done        node i finished its frame
//   in_packet      per-node payload
//   tx_id, rx_id   per-node transmit ID; rx_id[i] mirrors tx_id[i^1]
//   grant          one-cycle one-hot pulse when a node is loaded
//   busy           node holds an in-flight frame
//   drop_count     saturating count of frames aborted after MAX_RETRY
// -----------------------------------------------------------------------------
module can_tx_scheduler
  import can_tx_scheduler_pkg::*;
#(
  parameter int TOTAL_NODES = can_tx_scheduler_pkg::TOTAL_NODES,
  parameter int DATA_SIZE   = can_tx_scheduler_pkg::DATA_SIZE,
  parameter int ID_SIZE     = can_tx_scheduler_pkg::ID_SIZE,
  parameter int MAX_RETRY   = can_tx_scheduler_pkg::MAX_RETRY
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             cfg_valid,
  input  logic [TOTAL_NODES*ID_SIZE-1:0]   cfg_id,
  output logic                             cfg_done,
  input  logic                             pkt_valid,
  input  logic [DATA_SIZE-1:0]             pkt_data,
  output logic                             pkt_ready,
  input  logic [TOTAL_NODES-1:0]           data_in_req,
  input  logic [TOTAL_NODES-1:0]           retransmit,
  input  logic [TOTAL_NODES-1:0]           tx_done,
  output logic [TOTAL_NODES*DATA_SIZE-1:0] in_packet,
  output logic [TOTAL_NODES*ID_SIZE-1:0]   tx_id,
  output logic [TOTAL_NODES*ID_SIZE-1:0]   rx_id,
  output logic [TOTAL_NODES-1:0]           grant,
  output logic [TOTAL_NODES-1:0]           busy,
  output logic [15:0]                      drop_count
);

  localparam int PW = $clog2(TOTAL_NODES);
  localparam int RW = 4;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [PW-1:0] onehot_to_idx(input logic [TOTAL_NODES-1:0] oh);
    logic [PW-1:0] r;
    r = '0;
    for (int k = 0; k < TOTAL_NODES; k++) begin
      if (oh[k]) r = r | PW'(k);
    end
    return r;
  endfunction

  sched_state_t           state, state_nx;
  logic [ID_SIZE-1:0]     id_table [TOTAL_NODES];
  logic [PW-1:0]          ptr, ptr_nx, sel, sel_nx;
  logic [TOTAL_NODES-1:0] cand, arb_gnt;
  logic                   take;
  logic [TOTAL_NODES-1:0] drop_req, drop_pick;

  // Nodes already busy or currently retrying are never candidates.
  assign cand = data_in_req & ~busy & ~retransmit;

  can_tx_scheduler_rr_arbiter #(.N(TOTAL_NODES), .PW(PW)) u_arb (
    .req (cand),
    .ptr (ptr),
    .gnt (arb_gnt)
  );

  always_comb begin
    state_nx  = state;
    sel_nx    = sel;
    ptr_nx    = ptr;
    take      = 1'b0;
    pkt_ready = 1'b0;
    case (state)
      CFG_WAIT: if (cfg_valid) state_nx = IDLE;
      IDLE: begin
        if (|cand) begin
          sel_nx   = onehot_to_idx(arb_gnt);
          state_nx = FETCH;
        end
      end
      FETCH: begin
        // sel stays latched here even if its request drops.
        pkt_ready = pkt_valid;
        if (pkt_valid) begin
          take     = 1'b1;
          ptr_nx   = (sel == PW'(TOTAL_NODES - 1)) ? '0 : sel + PW'(1);
          state_nx = IDLE;
        end
      end
      default: state_nx = CFG_WAIT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= CFG_WAIT;
      ptr      <= '0;
      sel      <= '0;
      cfg_done <= 1'b0;
      grant    <= '0;
      for (int i = 0; i < TOTAL_NODES; i++) id_table[i] <= '0;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
      sel   <= sel_nx;
      grant <= take ? (TOTAL_NODES'(1) << sel) : '0;
      if (cfg_valid) begin
        cfg_done <= 1'b1;
        for (int i = 0; i < TOTAL_NODES; i++) id_table[i] <= cfg_id[i*ID_SIZE +: ID_SIZE];
      end
    end
  end

  // Only one drop is counted per cycle; lowest-index request goes first and
  // the rest wait in their per-node pending flag.
  assign drop_pick = drop_req & (~drop_req + TOTAL_NODES'(1));

  always_ff @(posedge clock) begin
    if (reset) drop_count <= '0;
    else if (|drop_req) drop_count <= sat_inc(drop_count);
  end

  for (genvar i = 0; i < TOTAL_NODES; i++) begin : g_node
    localparam int PEER = i ^ 1;

    logic                 busy_q, pend_q;
    logic [ID_SIZE-1:0]   tx_id_q;
    logic [DATA_SIZE-1:0] pkt_q;
    logic [RW-1:0]        retry_q;
    logic                 load, done, retx, abort;

    // A node being loaded is never busy, so load cannot collide with release.
    assign load  = take && (sel == PW'(i));
    assign done  = tx_done[i] & busy_q;
    assign retx  = retransmit[i] & busy_q & ~tx_done[i];
    assign abort = retx && (retry_q == RW'(MAX_RETRY - 1));

    assign drop_req[i] = abort | pend_q;

    always_ff @(posedge clock) begin
      if (reset) begin
        busy_q  <= 1'b0;
        pend_q  <= 1'b0;
        tx_id_q <= '0;
        pkt_q   <= '0;
        retry_q <= '0;
      end else begin
        pend_q <= drop_req[i] & ~drop_pick[i];
        if (load) begin
          busy_q  <= 1'b1;
          tx_id_q <= id_table[i];
          pkt_q   <= pkt_data;
        end else if (done || abort) begin
          busy_q  <= 1'b0;
          tx_id_q <= id_table[i];
          retry_q <= '0;
        end else if (retx) begin
          retry_q <= retry_q + RW'(1);
          tx_id_q <= '0;
        end
      end
    end

    assign busy[i]                          = busy_q;
    assign tx_id[i*ID_SIZE +: ID_SIZE]      = tx_id_q;
    assign in_packet[i*DATA_SIZE +: DATA_SIZE] = pkt_q;
    assign rx_id[i*ID_SIZE +: ID_SIZE]      = tx_id[PEER*ID_SIZE +: ID_SIZE];
  end

endmodule

// File: tb/tb_can_tx_scheduler.sv
module tb_can_tx_scheduler;

  localparam int N  = 4;
  localparam int DW = 64;
  localparam int IW = 11;
  localparam int MR = 8;

  logic            clock = 1'b0;
  logic            reset;
  logic            cfg_valid;
  logic [N*IW-1:0] cfg_id;
  logic            cfg_done;
  logic            pkt_valid;
  logic [DW-1:0]   pkt_data;
  logic            pkt_ready;
  logic [N-1:0]    data_in_req, retransmit, tx_done;
  logic [N*DW-1:0] in_packet;
  logic [N*IW-1:0] tx_id, rx_id;
  logic [N-1:0]    grant, busy;
  logic [15:0]     drop_count;

  always #5 clock = ~clock;

  can_tx_scheduler #(.TOTAL_NODES(N), .DATA_SIZE(DW), .ID_SIZE(IW), .MAX_RETRY(MR)) dut (
    .clock(clock), .reset(reset), .cfg_valid(cfg_valid), .cfg_id(cfg_id),
    .cfg_done(cfg_done), .pkt_valid(pkt_valid), .pkt_data(pkt_data),
    .pkt_ready(pkt_ready), .data_in_req(data_in_req), .retransmit(retransmit),
    .tx_done(tx_done), .in_packet(in_packet), .tx_id(tx_id), .rx_id(rx_id),
    .grant(grant), .busy(busy), .drop_count(drop_count)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  bit            m_cfg, m_has_sel;
  int            m_sel, m_ptr, m_drop, m_pend;
  logic [IW-1:0] m_table [N];
  logic [IW-1:0] m_txid  [N];
  logic [DW-1:0] m_pkt   [N];
  bit            m_busy  [N];
  int            m_retry [N];
  logic [N-1:0]  m_grant;

  always @(posedge clock) begin : model
    logic [N-1:0] cand;
    int aborts, pick;
    if (reset) begin
      m_cfg = 0; m_has_sel = 0; m_sel = 0; m_ptr = 0; m_drop = 0; m_pend = 0;
      m_grant = '0;
      for (int i = 0; i < N; i++) begin
        m_table[i] = '0; m_txid[i] = '0; m_pkt[i] = '0; m_busy[i] = 0; m_retry[i] = 0;
      end
    end else begin
      cand = '0;
      for (int i = 0; i < N; i++) cand[i] = data_in_req[i] && !m_busy[i] && !retransmit[i];
      pick = -1;
      for (int k = 0; k < N; k++)
        if (pick < 0 && cand[(m_ptr + k) % N]) pick = (m_ptr + k) % N;
      aborts = 0;
      m_grant = '0;
      for (int i = 0; i < N; i++) begin
        if (m_busy[i] && tx_done[i]) begin
          m_busy[i] = 0; m_retry[i] = 0; m_txid[i] = m_table[i];
        end else if (m_busy[i] && retransmit[i]) begin
          m_retry[i]++;
          if (m_retry[i] == MR) begin
            m_busy[i] = 0; m_retry[i] = 0; m_txid[i] = m_table[i]; aborts++;
          end else m_txid[i] = '0;
        end
      end
      if (!m_cfg) begin
        if (cfg_valid) m_cfg = 1;
      end else if (!m_has_sel) begin
        if (pick >= 0) begin m_sel = pick; m_has_sel = 1; end
      end else if (pkt_valid) begin
        m_pkt[m_sel] = pkt_data; m_txid[m_sel] = m_table[m_sel]; m_busy[m_sel] = 1;
        m_grant[m_sel] = 1'b1; m_ptr = (m_sel + 1) % N; m_has_sel = 0;
      end
      if (cfg_valid)
        for (int i = 0; i < N; i++) m_table[i] = cfg_id[i*IW +: IW];
      m_pend += aborts;
      if (m_pend > 0) begin
        if (m_drop < 16'hFFFF) m_drop++;
        m_pend--;
      end
    end
  end

  always @(negedge clock) begin : compare
    logic [N*IW-1:0] e_tx, e_rx;
    logic [N*DW-1:0] e_pkt;
    logic [N-1:0]    e_busy;
    if (chk_en) begin
      for (int i = 0; i < N; i++) begin
        e_tx[i*IW +: IW]  = m_txid[i];
        e_rx[i*IW +: IW]  = m_txid[i ^ 1];
        e_pkt[i*DW +: DW] = m_pkt[i];
        e_busy[i]         = m_busy[i];
      end
      check("grant", grant, m_grant);
      check("busy", busy, e_busy);
      check("tx_id", tx_id, e_tx);
      check("rx_id", rx_id, e_rx);
      check("in_packet", in_packet, e_pkt);
      check("drop_count", drop_count, m_drop);
      check("cfg_done", cfg_done, m_cfg);
      check("pkt_ready", pkt_ready, m_cfg && m_has_sel && pkt_valid);
    end
  end

  // ---------------- directed + random stimulus ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load_node(input int k, input logic [DW-1:0] d);
    bit got;
    got = 0;
    data_in_req = N'(1) << k; pkt_valid = 1'b1; pkt_data = d;
    for (int c = 0; c < 20 && !got; c++) begin
      tick();
      if (grant != '0) got = 1;
    end
    check("load_grant", grant, N'(1) << k);
    data_in_req = '0; pkt_valid = 1'b0;
  endtask

  localparam logic [N*IW-1:0] IDS = {11'h7FF, 11'h301, 11'h2A5, 11'h123};

  initial begin
    int order [5];
    int exp_order [5];
    int n;
    bit quiet;
    logic [DW-1:0] saved;

    reset = 1; cfg_valid = 0; cfg_id = '0; pkt_valid = 0; pkt_data = '0;
    data_in_req = '0; retransmit = '0; tx_done = '0;
    tick(); tick();
    chk_en = 1'b1;
    reset = 0;
    check("rst_cfg_done", cfg_done, 0);
    check("rst_busy", busy, 0);
    check("rst_tx_id", tx_id, 0);
    check("rst_drop", drop_count, 0);
    check("rst_grant", grant, 0);

    // config then single request
    cfg_id = IDS; cfg_valid = 1; tick(); cfg_valid = 0;
    check("cfg_done_set", cfg_done, 1);
    data_in_req = 4'b0001; pkt_valid = 1; pkt_data = 64'hDEAD_BEEF_0000_0001;
    tick();
    check("lat_first_cycle", grant, 0);
    tick();
    data_in_req = '0; pkt_valid = 0;
    check("single_grant", grant, 4'b0001);
    check("single_tx_id0", tx_id[10:0], 11'h123);
    check("single_rx_id1", rx_id[21:11], 11'h123);
    check("single_busy", busy, 4'b0001);
    check("single_pkt0", in_packet[63:0], 64'hDEAD_BEEF_0000_0001);
    tick();
    check("grant_pulse", grant, 0);

    // fairness from a fresh pointer
    reset = 1; tick(); reset = 0;
    cfg_id = IDS; cfg_valid = 1; tick(); cfg_valid = 0;
    exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 2; exp_order[3] = 3; exp_order[4] = 0;
    for (int k = 0; k < 5; k++) order[k] = -1;
    n = 0;
    data_in_req = 4'b1111; pkt_valid = 1;
    for (int c = 0; c < 40 && n < 5; c++) begin
      pkt_data = {$urandom, $urandom};
      tick();
      tx_done = grant;
      if (grant != '0) begin
        for (int k = 0; k < N; k++) if (grant[k]) order[n] = k;
        n++;
      end
    end
    data_in_req = '0;
    tick();
    tx_done = '0; pkt_valid = 0;
    tick();
    for (int k = 0; k < 5; k++) check($sformatf("rr_order_%0d", k), order[k], exp_order[k]);
    check("rr_all_released", busy, 0);

    // retransmit on node2
    load_node(2, 64'hCAFE_F00D_1234_5678);
    saved = in_packet[191:128];
    for (int p = 0; p < 3; p++) begin
      retransmit = 4'b0100; tick(); retransmit = '0;
      if (p == 0) begin
        check("retx_id_zero", tx_id[32:22], 0);
        check("retx_pkt_held", in_packet[191:128], 64'hCAFE_F00D_1234_5678);
      end
      tick();
    end
    check("retx_still_busy", busy[2], 1);
    tx_done = 4'b0100; tick(); tx_done = '0;
    check("done_id_restored", tx_id[32:22], 11'h301);
    check("done_busy_clr", busy[2], 0);
    check("done_pkt_kept", in_packet[191:128], saved);

    // abort on node1 after MAX_RETRY
    load_node(1, 64'h1111_2222_3333_4444);
    for (int p = 0; p < MR; p++) begin
      retransmit = 4'b0010; tick(); retransmit = '0;
      if (p == MR - 2) check("abort_not_yet", busy[1], 1);
      if (p == MR - 1) begin
        check("abort_busy", busy[1], 0);
        check("abort_drop", drop_count, 1);
        check("abort_id", tx_id[21:11], 11'h2A5);
      end
      tick();
    end

    // stall in FETCH
    data_in_req = 4'b1000; pkt_valid = 0; pkt_data = 64'h0BAD_0BAD_0BAD_0BAD;
    tick();
    data_in_req = '0;
    quiet = 1;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (pkt_ready || grant != '0) quiet = 0;
    end
    check("stall_quiet", quiet, 1);
    pkt_valid = 1; #1;
    check("stall_ready", pkt_ready, 1);
    tick(); pkt_valid = 0;
    check("stall_grant", grant, 4'b1000);
    check("stall_pkt", in_packet[255:192], 64'h0BAD_0BAD_0BAD_0BAD);

    // two aborts in the same cycle: counted on consecutive cycles
    load_node(0, 64'hA);
    load_node(2, 64'hB);
    for (int p = 0; p < MR; p++) begin
      retransmit = 4'b0101; tick(); retransmit = '0;
      if (p < MR - 1) tick();
    end
    check("dual_drop_first", drop_count, 2);
    tick();
    check("dual_drop_second", drop_count, 3);
    tx_done = 4'b1000; tick(); tx_done = '0;

    // tx_done wins over retransmit on the same node
    load_node(0, 64'hC);
    tx_done = 4'b0001; retransmit = 4'b0001; tick();
    tx_done = '0; retransmit = '0;
    check("sim_busy", busy[0], 0);
    check("sim_id", tx_id[10:0], 11'h123);
    tick();
    check("sim_drop", drop_count, 3);

    // reset while FETCH is pending
    data_in_req = 4'b0010; pkt_valid = 0; tick();
    reset = 1; data_in_req = '0; tick(); reset = 0;
    check("mid_rst_cfg", cfg_done, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_drop", drop_count, 0);
    check("mid_rst_pkt", in_packet, 0);
    pkt_valid = 1; #1;
    check("mid_rst_ready", pkt_ready, 0);
    tick(); tick();
    check("mid_rst_no_grant", grant, 0);
    pkt_valid = 0;

    // randomized traffic, checked by the model every cycle
    cfg_id = IDS; cfg_valid = 1; tick(); cfg_valid = 0;
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 499) == 0);
      cfg_valid = ($urandom_range(0, 49) == 0);
      for (int i = 0; i < N; i++) begin
        cfg_id[i*IW +: IW] = IW'($urandom);
        retransmit[i] = ($urandom_range(0, 7) == 0);
        tx_done[i]    = ($urandom_range(0, 11) == 0);
      end
      data_in_req = N'($urandom);
      pkt_valid   = ($urandom_range(0, 9) < 7);
      pkt_data    = {$urandom, $urandom};
      tick();
    end
    reset = 0; cfg_valid = 0; retransmit = '0; tx_done = '0; data_in_req = '0; pkt_valid = 0;
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/can_tx_scheduler.md
Name: can_tx_scheduler

Overview:
- Sequences transmit traffic onto the CAN node array.
- Arbitrates round-robin among nodes requesting a new frame (data_in_req) and pulls one packet per grant from the HVL packet stream (valid/ready).
- Drives each node's In_packet, Tx_ID and Rx_ID from a configured ID table.
- Owns retransmit handling: ID forced to 0, bounded retries, abort and drop count.

Parameters:
- TOTAL_NODES, 4, number of CAN nodes; must be even, because nodes are paired (i, i^1).
- DATA_SIZE, 64, packet width in bits.
- ID_SIZE, 11, CAN identifier width.
- MAX_RETRY, 8, retransmit attempts per frame before abort; range 1..15.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous active-high reset.
- cfg_valid  in  1  one-cycle strobe that loads the ID table.
- cfg_id  in  TOTAL_NODES*ID_SIZE  node i ID at [i*ID_SIZE +: ID_SIZE].
- cfg_done  out  1  ID table loaded.
- pkt_valid  in  1  packet source has data.
- pkt_data  in  DATA_SIZE  packet payload.
- pkt_ready  out  1  packet consumed this cycle.
- data_in_req  in  TOTAL_NODES  node i requests a new frame.
- retransmit  in  TOTAL_NODES  node i lost arbitration or errored; resend.
- tx_done  in  TOTAL_NODES  node i completed its frame successfully.
- in_packet  out  TOTAL_NODES*DATA_SIZE  per-node frame payload.
- tx_id  out  TOTAL_NODES*ID_SIZE  per-node transmit ID.
- rx_id  out  TOTAL_NODES*ID_SIZE  per-node expected receive ID.
- grant  out  TOTAL_NODES  one-hot, one-cycle pulse when a node is loaded.
- busy  out  TOTAL_NODES  node i holds an in-flight frame.
- drop_count  out  16  frames aborted after MAX_RETRY; saturating.

Behaviour:
- Reset (synchronous, active-high; clock clock): all outputs are 0, state is CFG_WAIT, round-robin pointer is 0, retry counters are 0, ID table is 0.
- FSM:
  - CFG_WAIT: pkt_ready=0 and no grants. cfg_valid latches the table, sets cfg_done=1 (sticky until reset) and moves to IDLE. A later cfg_valid in any state reloads the table only; in-flight tx_id values are not changed.
  - IDLE: candidate set = data_in_req & ~busy & ~retransmit. If non-empty, pick the first set bit at or after the pointer (wrapping), latch it as sel, go to FETCH.
  - FETCH: pkt_ready = pkt_valid. On transfer:
    - in_packet[sel] <= pkt_data; tx_id[sel] <= ID[sel]; busy[sel] <= 1; grant[sel] pulses the next cycle.
    - pointer <= sel+1 mod TOTAL_NODES; go to IDLE.
    - Latency: request to grant is 2 cycles minimum (IDLE, then FETCH with pkt_valid=1).
    - While pkt_valid=0, stay in FETCH. sel is held even if data_in_req[sel] drops.
- Retransmit, per node, independent of the FSM, evaluated every cycle:
  - retransmit[i] & busy[i]: retry[i]+1; tx_id[i] <= 0 (highest priority); in_packet[i] is held.
  - If retry reaches MAX_RETRY: abort. busy[i] <= 0; tx_id[i] <= ID[i]; retry[i] <= 0; drop_count +1, saturating at 16'hFFFF.
  - retransmit[i] with busy[i]=0 is ignored.
- Completion: tx_done[i] & busy[i] sets busy[i] <= 0, retry[i] <= 0 and tx_id[i] <= ID[i]. tx_done takes priority over a simultaneous retransmit on the same node.
- Pairing (combinational): rx_id[i] = tx_id[i^1].
- A node already busy is never granted again until it is released.
- Simultaneous events:
  - Grant and release of different nodes in the same cycle are both honoured.
  - drop_count increments by at most 1 per cycle; a second simultaneous abort is added next cycle via a 1-deep pending flag per node.
- Reset mid-FETCH discards the pending selection. A packet already accepted by pkt_ready is never replayed.

Decomposition:
- Shared package (def.pkg):
  - TOTAL_NODES, DATA_SIZE, ID_SIZE constants.
  - typedef enum logic [1:0] {CFG_WAIT, IDLE, FETCH} sched_state_t.
  - typedef logic [ID_SIZE-1:0] can_id_t.
- Sub-module rr_arbiter: parameter N; inputs req[N] and ptr; output one-hot gnt; purely combinational.
- Per-node retry and busy logic lives in a generate loop.

Test Plan:
- Config then single request: cfg_id node0=11'h123; data_in_req=4'b0001; pkt_data=64'hDEAD_BEEF_0000_0001 -> grant=4'b0001 two cycles later; tx_id[0]=11'h123; rx_id[1]=11'h123; busy[0]=1.
- Fairness: data_in_req=4'b1111 held, pkt_valid=1 always, tx_done pulsed after each grant -> grant order 0,1,2,3,0.
- Retransmit: node2 busy, retransmit[2] pulsed 3 times -> tx_id[2]=0 after the first pulse, in_packet[2] unchanged; then tx_done[2] -> tx_id[2]=ID[2], busy[2]=0.
- Abort: MAX_RETRY=8, 8 retransmit pulses on node1 -> busy[1]=0, drop_count=1, tx_id[1]=ID[1].
- Stall and backpressure: pkt_valid=0 for 10 cycles in FETCH -> pkt_ready=0, no grant; pkt_valid=1 -> grant on the next cycle.
- Reset mid-FETCH, and simultaneous tx_done[0] with retransmit[0] -> all outputs return to 0 and state to CFG_WAIT; the simultaneous case releases node0 with drop_count unchanged.
